// File: rtl/tlul_pkg.sv
// Minimal TL-UL type definitions shared by the GPIO arbiter and its bench.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  // Host-to-device: A channel plus the D-channel ready
  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  // Device-to-host: D channel plus the A-channel ready
  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/gpio_tlul_arb.sv
// Two-host TL-UL arbiter in front of the GPIO device port.
// One outstanding transaction at a time, round-robin grant, response routed
// by the latched owner (d_source is never inspected).
module gpio_tlul_arb (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tlul_pkg::tl_h2d_t tl_h0_i,
  output tlul_pkg::tl_d2h_t tl_h0_o,
  input  tlul_pkg::tl_h2d_t tl_h1_i,
  output tlul_pkg::tl_d2h_t tl_h1_o,
  output tlul_pkg::tl_h2d_t tl_dev_o,
  input  tlul_pkg::tl_d2h_t tl_dev_i,
  output logic              busy_o,
  output logic              owner_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   prio_q, prio_d;

  logic              any_req;
  logic              winner;
  logic              sel;
  logic              a_phase;
  logic              d_phase;
  logic              a_hs;
  logic              d_hs;
  tlul_pkg::tl_h2d_t req_sel;

  // Round-robin pick among requesting hosts; prio breaks ties
  always_comb begin
    any_req = tl_h0_i.a_valid | tl_h1_i.a_valid;
    winner  = 1'b0;
    if (tl_h0_i.a_valid && tl_h1_i.a_valid) begin
      winner = prio_q;
    end else if (tl_h1_i.a_valid) begin
      winner = 1'b1;
    end
  end

  // Host select: live winner in IDLE, locked owner otherwise; host 0 in reset
  always_comb begin
    sel = 1'b0;
    if (!rst_i) begin
      sel = (state_q == IDLE) ? winner : owner_q;
    end
    req_sel = sel ? tl_h1_i : tl_h0_i;
    // Handshake enables are gated by reset so nothing leaks out while held
    a_phase = !rst_i && (state_q != RESP);
    d_phase = !rst_i && (state_q == RESP);
  end

  // Device request: selected host's A fields, valid/ready gated by phase
  always_comb begin
    tl_dev_o         = req_sel;
    tl_dev_o.a_valid = a_phase & req_sel.a_valid;
    tl_dev_o.d_ready = d_phase & req_sel.d_ready;
  end

  // Host responses: D fields fan out, but valid/ready reach only the selected host
  always_comb begin
    tl_h0_o         = tl_dev_i;
    tl_h0_o.a_ready = a_phase & ~sel & tl_dev_i.a_ready;
    tl_h0_o.d_valid = d_phase & ~sel & tl_dev_i.d_valid;
    tl_h1_o         = tl_dev_i;
    tl_h1_o.a_ready = a_phase & sel & tl_dev_i.a_ready;
    tl_h1_o.d_valid = d_phase & sel & tl_dev_i.d_valid;
  end

  // Next-state logic for the grant FSM
  always_comb begin
    a_hs    = tl_dev_o.a_valid & tl_dev_i.a_ready;
    d_hs    = tl_dev_i.d_valid & tl_dev_o.d_ready;
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          state_d = a_hs ? RESP : ADDR;
        end
      end
      ADDR: begin
        if (a_hs) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (d_hs) begin
          state_d = IDLE;
          prio_d  = ~owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant FSM registers; reset abandons any in-flight transaction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign owner_o = owner_q;

endmodule
